bus_mem: RTL
============

Name: bus_mem

Overview:
Parametrised single-port synchronous bus memory. It is the successor to the fixed 64 KiB x 8 bench RAM. It adds configurable address and data width, configurable read latency, an address-mirroring window (2 KiB console RAM style), a write-protected ROM window, and a read-valid strobe. It sits on the CPU address/data bus in benches and FPGA top levels, and is clocked on the edge opposite the CPU.

Parameters:
ADDR_W, 16, address width; array depth is 2**ADDR_W words.
DATA_W, 8, data word width.
READ_LATENCY, 1, number of clock edges from read request to data_out; legal range 1..4.
MIRROR_LIMIT, 16'h2000, addresses below this value are mirrored.
MIRROR_MASK, 16'h07FF, AND mask applied to addresses below MIRROR_LIMIT.
ROM_BASE, 16'h8000, addresses >= ROM_BASE are write-protected.

Ports:
clock  input  1  memory clock; all logic on posedge.
nreset  input  1  synchronous, active-low reset.
ce  input  1  access enable; 0 = idle cycle.
addr  input  ADDR_W  bus address.
rw  input  1  1 = read, 0 = write.
data_in  input  DATA_W  write data.
data_out  output  DATA_W  registered read data.
rd_valid  output  1  high for one cycle when data_out carries a fresh read result.
wp_fault  output  1  one-cycle pulse on an attempted write to the ROM window.

Behaviour:
- Effective address: eff = (addr < MIRROR_LIMIT) ? (addr & MIRROR_MASK) : addr. Both read and write use eff.
- Write (ce=1, rw=0, addr < ROM_BASE): memory[eff] <= data_in at the posedge. The value is visible to a read issued on the next cycle.
- Protected write (ce=1, rw=0, addr >= ROM_BASE): array unchanged. wp_fault=1 on the following cycle, for 1 cycle.
- Read (ce=1, rw=1): memory[eff] is captured at the posedge, then shifts through READ_LATENCY-1 further pipeline stages. data_out and rd_valid update together. Latency 1 means data is valid the cycle after the request.
- Write or idle cycles enter the pipeline as bubbles. When a bubble reaches the output: rd_valid=0 and data_out=0, matching the legacy "zero on write" bus behaviour. The optional feature below changes this.
- Back-to-back reads are fully pipelined at one per cycle, with no stalls.
- Single port: one access per cycle, so there are no simultaneous-access conflicts.
- Reset (nreset=0 at a posedge):
  - data_out=0, rd_valid=0, wp_fault=0.
  - All pipeline stages are flushed to bubbles.
  - Writes presented during reset are suppressed.
  - Array contents are preserved; reset never clears memory.
- Reset asserted mid-read: the in-flight read is discarded, and no rd_valid appears after reset release.
- Address wrap: eff is ADDR_W bits with no carry, so the top address 2**ADDR_W-1 is a legal ordinary location.
- Array is preloadable by hierarchical access or $readmemh; no reset-time initialisation.

Optional Feature:
BUS_MEM_OPEN_BUS_EN
- Defined: on bubble cycles data_out holds its last driven value (open-bus emulation). rd_valid still deasserts.
- Undefined: bubbles drive data_out=0.
- Reset clears data_out to 0 in both builds.

Test Plan:
- Defaults, write $0123 <= $5A, then read $0923 (mirror) -> data_out=$5A with rd_valid=1 one cycle after the read request; the $0923 read goes to array entry $0123.
- Preload memory[$8000]=$A9, write $8000 <= $00 -> wp_fault pulses 1 cycle; a later read of $8000 returns $A9.
- READ_LATENCY=3, reads of $0010/$0011/$0012 on consecutive cycles (preloaded $11/$22/$33) -> rd_valid high for 3 consecutive cycles starting 3 cycles after the first request, data $11,$22,$33.
- READ_LATENCY=2, read $0200 (=$77), then nreset=0 for 1 cycle before the result emerges -> data_out=0, rd_valid never asserts; memory[$0200] is still $77 after reset.
- Read $0300 (=$C3), then a write cycle: without BUS_MEM_OPEN_BUS_EN, data_out returns to $00 the cycle after; with it, data_out stays $C3 and rd_valid=0.
- ADDR_W=12, DATA_W=16, MIRROR_LIMIT=0, write $FFF <= $BEEF, read $FFF -> $BEEF; location $000 is unaffected.

Source files
------------

// File: rtl/bus_mem.sv
// Single-port synchronous bus memory: address mirroring, write-protected ROM window,
// READ_LATENCY-deep read pipeline. Define BUS_MEM_OPEN_BUS_EN to hold data_out on bubbles.
module bus_mem #(
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [31:0] MIRROR_LIMIT = 32'h2000,
   parameter logic [31:0] MIRROR_MASK  = 32'h07FF,
   parameter logic [31:0] ROM_BASE     = 32'h8000
) (
   input  logic              clock,
   input  logic              nreset,
   input  logic              ce,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rw,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              wp_fault
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [31:0]       addr_ext;
   logic              mirror_hit;
   logic              rom_hit;
   logic              rd_req;
   logic              wr_req;
   logic [ADDR_W-1:0] eff;

   logic [READ_LATENCY-1:0]             vld_pipe_q, vld_pipe_d;
   logic [READ_LATENCY-1:0][DATA_W-1:0] dat_pipe_q, dat_pipe_d;
   logic                                wp_fault_q, wp_fault_d;

   always_comb begin
      addr_ext   = 32'(addr);
      mirror_hit = addr_ext < MIRROR_LIMIT;
      rom_hit    = addr_ext >= ROM_BASE;
      eff        = mirror_hit ? (addr & MIRROR_MASK[ADDR_W-1:0]) : addr;
      rd_req     = ce && rw;
      // Writes seen while in reset must never reach the array.
      wr_req     = nreset && ce && !rw && !rom_hit;
   end

   always_ff @(posedge clock) begin
      if (wr_req) mem[eff] <= data_in;
   end

   always_comb begin
      vld_pipe_d    = '0;
      dat_pipe_d    = '0;
      vld_pipe_d[0] = rd_req;
      dat_pipe_d[0] = rd_req ? mem[eff] : '0;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
         vld_pipe_d[i] = vld_pipe_q[i-1];
         dat_pipe_d[i] = dat_pipe_q[i-1];
      end
`ifdef BUS_MEM_OPEN_BUS_EN
      // Open bus: a bubble at the output stage keeps the last driven value.
      if (!vld_pipe_d[READ_LATENCY-1])
         dat_pipe_d[READ_LATENCY-1] = dat_pipe_q[READ_LATENCY-1];
`endif
      wp_fault_d = ce && !rw && rom_hit;
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         vld_pipe_q <= '0;
         dat_pipe_q <= '0;
         wp_fault_q <= 1'b0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         dat_pipe_q <= dat_pipe_d;
         wp_fault_q <= wp_fault_d;
      end
   end

   assign data_out = dat_pipe_q[READ_LATENCY-1];
   assign rd_valid = vld_pipe_q[READ_LATENCY-1];
   assign wp_fault = wp_fault_q;

endmodule
